// File: rtl/branch_resolver.sv
// branch_resolver
//    Execute-side companion to the fetch-stage BTB. Every instruction fetch
//    issues is recorded in a small in-order queue together with the next-PC
//    that fetch predicted for it. When execute resolves the oldest
//    instruction, the real next-PC is compared against that prediction.
//    On a mismatch the resolver:
//       - pulses redirect with the correct PC;
//       - flushes the queue, because every younger entry is wrong-path;
//       - writes the BTB when the branch was taken.
//
// Parameters
//    DEPTH  in-flight queue entries (power of two, >= 2)
//    CNT_W  width of the saturating statistics counters
//
// Ports
//    clk, rst_n                                  clock, async active-low reset
//    fetch_valid, fetch_pc                       instruction issued by fetch
//    pred_hit, pred_target                       BTB lookup result for fetch_pc
//    exec_valid, exec_pc, exec_taken,
//       exec_target                              resolution of the oldest entry
//    stall_fetch                                 queue full, fetch must hold
//    redirect, redirect_pc                       one-cycle restart request
//    btb_load, btb_pc, btb_target                one-cycle BTB fill write
//    q_count                                     occupied queue entries
//    branch_count                                taken resolutions (saturating)
//    mispredict_count                            redirects issued (saturating)
//    proto_err                                   sticky protocol violation flag
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fetch_valid,
   input  logic [31:0]              fetch_pc,
   input  logic                     pred_hit,
   input  logic [31:0]              pred_target,
   input  logic                     exec_valid,
   input  logic [31:0]              exec_pc,
   input  logic                     exec_taken,
   input  logic [31:0]              exec_target,
   output logic                     stall_fetch,
   output logic                     redirect,
   output logic [31:0]              redirect_pc,
   output logic                     btb_load,
   output logic [31:0]              btb_pc,
   output logic [31:0]              btb_target,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic [CNT_W-1:0]         branch_count,
   output logic [CNT_W-1:0]         mispredict_count,
   output logic                     proto_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int QW = AW + 1;
   localparam logic [QW-1:0]    FULL_CNT = QW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Queue storage: no reset needed, occupancy is tracked by count_reg.
   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      pred_mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [QW-1:0]    count_reg;
   logic             redirect_reg;
   logic [31:0]      redirect_pc_reg;
   logic             btb_load_reg;
   logic [31:0]      btb_pc_reg, btb_target_reg;
   logic [CNT_W-1:0] branch_cnt_reg, mispredict_cnt_reg;
   logic             proto_err_reg;

   logic             full, empty, fetch_live, pop, push, mispredict_now, err_now;
   logic [31:0]      head_pc, head_pred, fetch_pred, actual_next;

   always_comb begin
      full        = (count_reg == FULL_CNT);
      empty       = (count_reg == '0);
      head_pc     = pc_mem[rd_ptr_reg];
      head_pred   = pred_mem[rd_ptr_reg];
      fetch_pred  = pred_hit ? pred_target : fetch_pc + 32'd4;
      actual_next = exec_taken ? exec_target : exec_pc + 32'd4;
      // The cycle a redirect is visible, the fetch on the bus is wrong-path
      // and the queue is already empty, so both sides are ignored.
      fetch_live  = fetch_valid & ~redirect_reg;
      pop         = exec_valid & ~empty & ~redirect_reg;
      mispredict_now = pop & (actual_next != head_pred);
      // A full queue still accepts a push when the head leaves this cycle;
      // a push racing a mispredict is wrong-path and is dropped.
      push        = fetch_live & (~full | pop) & ~mispredict_now;
      err_now     = (exec_valid & empty & ~redirect_reg)
                  | (fetch_live & full & ~pop)
                  | (pop & (exec_pc != head_pc));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= fetch_pc;
         pred_mem[wr_ptr_reg] <= fetch_pred;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         count_reg          <= '0;
         redirect_reg       <= 1'b0;
         redirect_pc_reg    <= '0;
         btb_load_reg       <= 1'b0;
         btb_pc_reg         <= '0;
         btb_target_reg     <= '0;
         branch_cnt_reg     <= '0;
         mispredict_cnt_reg <= '0;
         proto_err_reg      <= 1'b0;
      end else begin
         if (mispredict_now) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + QW'(push) - QW'(pop);
         end

         redirect_reg <= mispredict_now;
         if (mispredict_now) redirect_pc_reg <= actual_next;

         // Only a taken branch that fetch got wrong needs a BTB (re)write.
         btb_load_reg <= mispredict_now & exec_taken;
         if (mispredict_now && exec_taken) begin
            btb_pc_reg     <= exec_pc;
            btb_target_reg <= exec_target;
         end

         if (pop && exec_taken && branch_cnt_reg != CNT_MAX)
            branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
         if (mispredict_now && mispredict_cnt_reg != CNT_MAX)
            mispredict_cnt_reg <= mispredict_cnt_reg + CNT_W'(1);

         if (err_now) proto_err_reg <= 1'b1;
      end
   end

   assign stall_fetch      = full;
   assign redirect         = redirect_reg;
   assign redirect_pc      = redirect_pc_reg;
   assign btb_load         = btb_load_reg;
   assign btb_pc           = btb_pc_reg;
   assign btb_target       = btb_target_reg;
   assign q_count          = count_reg;
   assign branch_count     = branch_cnt_reg;
   assign mispredict_count = mispredict_cnt_reg;
   assign proto_err        = proto_err_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver
//    Directed scenarios plus a randomized run for branch_resolver. Expected
//    values come from a queue-based reference model updated on every clock
//    edge. The counters are built narrow here so that saturation can be
//    reached in a short run.
module tb_branch_resolver;

   localparam int DEPTH    = 4;
   localparam int TB_CNT_W = 8;
   localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                fetch_valid = 1'b0;
   logic [31:0]         fetch_pc = '0;
   logic                pred_hit = 1'b0;
   logic [31:0]         pred_target = '0;
   logic                exec_valid = 1'b0;
   logic [31:0]         exec_pc = '0;
   logic                exec_taken = 1'b0;
   logic [31:0]         exec_target = '0;
   logic                stall_fetch, redirect, btb_load, proto_err;
   logic [31:0]         redirect_pc, btb_pc, btb_target;
   logic [2:0]          q_count;
   logic [TB_CNT_W-1:0] branch_count, mispredict_count;

   int n_cmp = 0;
   int n_bad = 0;

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_hit(pred_hit), .pred_target(pred_target),
      .exec_valid(exec_valid), .exec_pc(exec_pc),
      .exec_taken(exec_taken), .exec_target(exec_target),
      .stall_fetch(stall_fetch), .redirect(redirect), .redirect_pc(redirect_pc),
      .btb_load(btb_load), .btb_pc(btb_pc), .btb_target(btb_target),
      .q_count(q_count), .branch_count(branch_count),
      .mispredict_count(mispredict_count), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   ent_t        q[$];
   logic        m_redirect, m_btb_load, m_err;
   logic [31:0] m_redirect_pc, m_btb_pc, m_btb_target;
   int          m_branch, m_mis;

   function automatic void m_reset();
      q.delete();
      m_redirect = 0; m_btb_load = 0; m_err = 0;
      m_redirect_pc = 0; m_btb_pc = 0; m_btb_target = 0;
      m_branch = 0; m_mis = 0;
   endfunction

   // Applies one clock edge worth of behaviour using the current inputs.
   function automatic void model_update();
      logic        was_redirect = m_redirect;
      logic        popping = exec_valid && q.size() > 0 && !was_redirect;
      logic        mis = 0;
      logic [31:0] actual = 0;
      m_redirect = 0;
      m_btb_load = 0;
      if (exec_valid && !was_redirect && q.size() == 0) m_err = 1;
      if (fetch_valid && !was_redirect && q.size() == DEPTH && !popping) m_err = 1;
      if (popping) begin
         actual = exec_taken ? exec_target : exec_pc + 4;
         if (q[0].pc != exec_pc) m_err = 1;
         if (exec_taken && m_branch < CNT_SAT) m_branch++;
         mis = (actual != q[0].pred);
         void'(q.pop_front());
      end
      if (mis) begin
         q.delete();
         m_redirect = 1;
         m_redirect_pc = actual;
         if (m_mis < CNT_SAT) m_mis++;
         if (exec_taken) begin
            m_btb_load = 1; m_btb_pc = exec_pc; m_btb_target = exec_target;
         end
      end else if (fetch_valid && !was_redirect && q.size() < DEPTH) begin
         q.push_back('{pc: fetch_pc, pred: pred_hit ? pred_target : fetch_pc + 32'd4});
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic fv, input logic [31:0] fpc, input logic ph,
                       input logic [31:0] pt, input logic ev, input logic [31:0] epc,
                       input logic et, input logic [31:0] etg);
      fetch_valid = fv; fetch_pc = fpc; pred_hit = ph; pred_target = pt;
      exec_valid = ev; exec_pc = epc; exec_taken = et; exec_target = etg;
      @(posedge clk);
      model_update();
      #1;
      if (fv || ev)
         $display("xact t=%0t fetch=%0b pc=%h hit=%0b tgt=%h | exec=%0b pc=%h tk=%0b tgt=%h | q=%0d rd=%0b",
                  $time, fv, fpc, ph, pt, ev, epc, et, etg, q_count, redirect);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input logic ph, input logic [31:0] pt);
      step(1, pc, ph, pt, 0, 0, 0, 0);
   endtask

   task automatic pop(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      step(0, 0, 0, 0, 1, pc, tk, tg);
   endtask

   task automatic reset_dut();
      rst_n = 0;
      fetch_valid = 0; exec_valid = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      m_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_dut();
      push(32'h200, 0, 0);
      push(32'h204, 0, 0);
      pop(32'h200, 1, 32'h400);
      if (redirect !== 1'b1) begin
         n_bad++; $display("FAIL reset_pre_redirect: got %0b want 1", redirect);
      end
      n_cmp++;
      // Drop reset between edges: everything must clear without a clock.
      #2 rst_n = 0;
      #1;
      m_reset();
      if ({redirect, btb_load, proto_err, stall_fetch} !== 4'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {redirect, btb_load, proto_err, stall_fetch});
      end
      n_cmp++;
      if (q_count !== 3'd0 || branch_count !== '0 || mispredict_count !== '0) begin
         n_bad++; $display("FAIL reset_counts: q=%0d br=%0d mis=%0d want 0/0/0", q_count, branch_count, mispredict_count);
      end
      n_cmp++;
      if (redirect_pc !== 32'h0 || btb_pc !== 32'h0 || btb_target !== 32'h0) begin
         n_bad++; $display("FAIL reset_pcs: rpc=%h bpc=%h btgt=%h want 0", redirect_pc, btb_pc, btb_target);
      end
      n_cmp++;
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_fallthrough();
      reset_dut();
      push(32'h100, 0, 0);
      pop(32'h100, 0, 0);
      if (redirect !== 1'b0 || btb_load !== 1'b0) begin
         n_bad++; $display("FAIL fallthrough_pulses: redirect=%0b btb_load=%0b want 0/0", redirect, btb_load);
      end
      n_cmp++;
      if (branch_count !== '0 || mispredict_count !== '0 || q_count !== 3'd0) begin
         n_bad++; $display("FAIL fallthrough_counts: br=%0d mis=%0d q=%0d want 0/0/0", branch_count, mispredict_count, q_count);
      end
      n_cmp++;
   endtask

   task automatic test_cold_taken();
      reset_dut();
      push(32'h200, 0, 0);
      push(32'h204, 0, 0);
      pop(32'h200, 1, 32'h400);
      if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin
         n_bad++; $display("FAIL cold_redirect: redirect=%0b pc=%h want 1 pc=00000400", redirect, redirect_pc);
      end
      n_cmp++;
      if (btb_load !== 1'b1 || btb_pc !== 32'h200 || btb_target !== 32'h400) begin
         n_bad++; $display("FAIL cold_btb: load=%0b pc=%h tgt=%h want 1/200/400", btb_load, btb_pc, btb_target);
      end
      n_cmp++;
      if (q_count !== 3'd0 || mispredict_count !== 8'd1 || branch_count !== 8'd1) begin
         n_bad++; $display("FAIL cold_counts: q=%0d mis=%0d br=%0d want 0/1/1", q_count, mispredict_count, branch_count);
      end
      n_cmp++;
      // A fetch during the redirect cycle is wrong-path and must not enqueue.
      push(32'h204, 0, 0);
      if (redirect !== 1'b0 || btb_load !== 1'b0 || q_count !== 3'd0) begin
         n_bad++; $display("FAIL cold_pulse_end: redirect=%0b load=%0b q=%0d want 0/0/0", redirect, btb_load, q_count);
      end
      n_cmp++;
   endtask

   task automatic test_correct_taken();
      reset_dut();
      push(32'h200, 1, 32'h400);
      pop(32'h200, 1, 32'h400);
      if (redirect !== 1'b0 || btb_load !== 1'b0) begin
         n_bad++; $display("FAIL correct_taken_pulses: redirect=%0b load=%0b want 0/0", redirect, btb_load);
      end
      n_cmp++;
      if (branch_count !== 8'd1 || mispredict_count !== 8'd0) begin
         n_bad++; $display("FAIL correct_taken_counts: br=%0d mis=%0d want 1/0", branch_count, mispredict_count);
      end
      n_cmp++;
   endtask

   task automatic test_full_wrap();
      reset_dut();
      for (int k = 0; k < DEPTH; k++) push(32'h1000 + 32'(4 * k), 0, 0);
      if (stall_fetch !== 1'b1 || q_count !== 3'd4) begin
         n_bad++; $display("FAIL full_stall: stall=%0b q=%0d want 1/4", stall_fetch, q_count);
      end
      n_cmp++;
      // Push+pop against a full queue, then keep streaming so the pointers wrap.
      for (int k = DEPTH; k < DEPTH + 10; k++) begin
         step(1, 32'h1000 + 32'(4 * k), 0, 0, 1, 32'h1000 + 32'(4 * (k - DEPTH)), 0, 0);
         if (q_count !== 3'd4 || redirect !== 1'b0 || proto_err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_stream k=%0d: q=%0d redirect=%0b err=%0b want 4/0/0", k, q_count, redirect, proto_err);
         end
         n_cmp++;
      end
      for (int k = 10; k < 14; k++) pop(32'h1000 + 32'(4 * k), 0, 0);
      if (q_count !== 3'd0 || redirect !== 1'b0 || proto_err !== 1'b0 || stall_fetch !== 1'b0) begin
         n_bad++; $display("FAIL wrap_drain: q=%0d redirect=%0b err=%0b stall=%0b want 0/0/0/0",
                           q_count, redirect, proto_err, stall_fetch);
      end
      n_cmp++;
   endtask

   task automatic test_random();
      logic        fv, ph, ev, et;
      logic [31:0] fpc, pt, epc, etg;
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         ev = 0; epc = 0; et = 0; etg = 0;
         if (q.size() > 0 && !m_redirect && $urandom_range(0, 1) == 1) begin
            ev = 1; epc = q[0].pc;
            case ($urandom_range(0, 2))
               0: begin et = (q[0].pred != epc + 4); etg = q[0].pred; end
               1: begin et = 1; etg = {$urandom_range(0, 255), 2'b00}; end
               default: begin et = 0; etg = $urandom; end
            endcase
         end
         fv = ($urandom_range(0, 2) != 0) && !(q.size() == DEPTH && !ev);
         fpc = {$urandom_range(0, 255), 2'b00};
         ph = $urandom_range(0, 1);
         pt = {$urandom_range(0, 255), 2'b00};
         step(fv, fpc, ph, pt, ev, epc, et, etg);
         if (q_count !== 3'(q.size()) || stall_fetch !== (q.size() == DEPTH)) begin
            n_bad++; $display("FAIL rand_queue c=%0d: q=%0d stall=%0b want q=%0d", c, q_count, stall_fetch, q.size());
         end
         n_cmp++;
         if (redirect !== m_redirect || (m_redirect && redirect_pc !== m_redirect_pc)) begin
            n_bad++; $display("FAIL rand_redirect c=%0d: %0b/%h want %0b/%h", c, redirect, redirect_pc, m_redirect, m_redirect_pc);
         end
         n_cmp++;
         if (btb_load !== m_btb_load || btb_pc !== m_btb_pc || btb_target !== m_btb_target) begin
            n_bad++; $display("FAIL rand_btb c=%0d: %0b/%h/%h want %0b/%h/%h", c, btb_load, btb_pc, btb_target,
                              m_btb_load, m_btb_pc, m_btb_target);
         end
         n_cmp++;
         if (branch_count !== TB_CNT_W'(m_branch) || mispredict_count !== TB_CNT_W'(m_mis) || proto_err !== m_err) begin
            n_bad++; $display("FAIL rand_stats c=%0d: br=%0d mis=%0d err=%0b want %0d/%0d/%0b", c, branch_count,
                              mispredict_count, proto_err, m_branch, m_mis, m_err);
         end
         n_cmp++;
      end
   endtask

   task automatic test_errors();
      reset_dut();
      pop(32'h100, 0, 0);
      if (proto_err !== 1'b1 || q_count !== 3'd0) begin
         n_bad++; $display("FAIL err_empty_pop: err=%0b q=%0d want 1/0", proto_err, q_count);
      end
      n_cmp++;
      idle();
      if (proto_err !== 1'b1) begin
         n_bad++; $display("FAIL err_sticky: err=%0b want 1", proto_err);
      end
      n_cmp++;
      for (int k = 0; k < DEPTH; k++) push(32'h2000 + 32'(4 * k), 0, 0);
      push(32'h9000, 0, 0);
      if (q_count !== 3'd4) begin
         n_bad++; $display("FAIL err_full_push: q=%0d want 4", q_count);
      end
      n_cmp++;
      for (int k = 0; k < DEPTH; k++) pop(32'h2000 + 32'(4 * k), 0, 0);
      if (q_count !== 3'd0 || redirect !== 1'b0 || mispredict_count !== 8'd0) begin
         n_bad++; $display("FAIL err_full_drain: q=%0d redirect=%0b mis=%0d want 0/0/0", q_count, redirect, mispredict_count);
      end
      n_cmp++;
      // Wrong exec_pc: flagged, but resolution still uses exec_pc.
      reset_dut();
      push(32'h100, 0, 0);
      pop(32'h104, 0, 0);
      if (proto_err !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h108 || btb_load !== 1'b0) begin
         n_bad++; $display("FAIL err_pc_mismatch: err=%0b redirect=%0b pc=%h load=%0b want 1/1/00000108/0",
                           proto_err, redirect, redirect_pc, btb_load);
      end
      n_cmp++;
   endtask

   task automatic test_saturate();
      reset_dut();
      for (int i = 0; i < CNT_SAT + 5; i++) begin
         push(32'h3000, 0, 0);
         pop(32'h3000, 1, 32'h5000);
         if (mispredict_count !== TB_CNT_W'(m_mis) || btb_load !== 1'b1) begin
            n_bad++; $display("FAIL sat_step i=%0d: mis=%0d load=%0b want %0d/1", i, mispredict_count, btb_load, m_mis);
         end
         n_cmp++;
         idle();
      end
      if (mispredict_count !== 8'hFF || branch_count !== 8'hFF || proto_err !== 1'b0) begin
         n_bad++; $display("FAIL sat_final: mis=%h br=%h err=%0b want ff/ff/0", mispredict_count, branch_count, proto_err);
      end
      n_cmp++;
   endtask

   initial begin
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      test_reset();
      test_fallthrough();
      test_cold_taken();
      test_correct_taken();
      test_full_wrap();
      test_random();
      test_errors();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-side companion to the fetch-stage branch target buffer. Records every prediction fetch makes in a small in-order queue. When execute resolves each instruction, it compares the resolved next-PC against the recorded prediction. On a mismatch it issues a redirect and flushes the queue, and it generates the BTB fill writes. Sits between fetch, execute and the BTB write port.

## Interface
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)
- CNT_W, 16, width of statistics counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch issues instruction at fetch_pc this cycle
- fetch_pc  in  32  PC of issued instruction
- pred_hit  in  1  BTB hit for fetch_pc
- pred_target  in  32  BTB target (meaningful only when pred_hit)
- exec_valid  in  1  execute resolves the oldest in-flight instruction
- exec_pc  in  32  PC of resolved instruction
- exec_taken  in  1  resolved pcmux_sel (control transfer taken)
- exec_target  in  32  resolved target (alu_out)
- stall_fetch  out  1  queue full; fetch must hold
- redirect  out  1  one-cycle pulse: fetch restarts at redirect_pc
- redirect_pc  out  32  correct next PC
- btb_load  out  1  one-cycle BTB write strobe
- btb_pc  out  32  BTB tag/index PC
- btb_target  out  32  BTB data
- q_count  out  $clog2(DEPTH)+1  occupied entries
- branch_count  out  CNT_W  resolved taken instructions, saturating
- mispredict_count  out  CNT_W  redirects issued, saturating
- proto_err  out  1  sticky protocol error

## Operation
- Queue entry: {pc, pred_next}. pred_next = pred_hit ? pred_target : fetch_pc+4 (mod 2^32).
- Push: fetch_valid & ~full & ~redirect & ~mispredict_now. Pop: exec_valid & ~empty.
- Resolution, on pop: actual_next = exec_taken ? exec_target : exec_pc+4. mispredict_now = (actual_next != head.pred_next).
- Mispredict:
  - next cycle: redirect=1, redirect_pc=actual_next.
  - Queue is cleared; all entries are younger wrong-path instructions.
  - A same-cycle push is dropped.
  - mispredict_count increments.
- BTB fill: on pop with exec_taken & mispredict_now, next cycle btb_load=1, btb_pc=exec_pc, btb_target=exec_target. A correct taken prediction does not rewrite. Not-taken never writes.
- branch_count increments on every pop with exec_taken.
- Both counters saturate at all-ones.
- proto_err is set and held until reset on any of these. The offending event is otherwise ignored.
  - exec_valid while empty.
  - fetch_valid while full and not stalled-acknowledged; a push attempt while full is dropped.
  - exec_pc != head.pc on pop. Resolution still proceeds using exec_pc.
- While redirect=1: fetch_valid is ignored because that fetch is wrong-path. exec_valid is also ignored, because the queue is empty.

## Timing
- Reset (async, rst_n low): queue empty, q_count=0, redirect=0, redirect_pc=0, btb_load=0, btb_pc=0, btb_target=0, both counters 0, proto_err=0.
- Reset mid-operation discards all entries immediately.
- stall_fetch = (q_count==DEPTH), combinational from registered count. All other outputs are registered.
- Resolve-to-redirect latency: 1 cycle. Resolve-to-btb_load latency: 1 cycle. Redirect and btb_load on a mispredicted taken branch assert in the same cycle.
- redirect and btb_load are single-cycle pulses. Back-to-back pulses are impossible, because the queue is empty after a redirect.
- Simultaneous push and pop without mispredict: q_count unchanged. Push into a full queue in the same cycle as a pop is accepted.
- Pointers wrap modulo DEPTH. q_count distinguishes full from empty.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> all outputs 0, q_count=0 asynchronously.
- Correct fall-through: push pc=0x100 pred_hit=0; pop exec_pc=0x100 exec_taken=0 -> no redirect, no btb_load, counters 0.
- Cold taken branch:
  - Stimulus: push 0x200 pred_hit=0, push 0x204; pop exec_pc=0x200 taken target=0x400.
  - Response next cycle: redirect=1 with redirect_pc=0x400; btb_load=1 with btb_pc=0x200, btb_target=0x400; q_count=0; mispredict_count=1, branch_count=1.
- Correct taken prediction: push 0x200 pred_hit=1 pred_target=0x400; pop taken target 0x400 -> no redirect, no btb_load, branch_count=1.
- Full/wrap:
  - Push 4 entries -> stall_fetch=1.
  - Push+pop same cycle -> accepted, q_count stays 4.
  - Run 10 entries through -> order preserved across wrap.
- Errors:
  - exec_valid with empty queue -> proto_err=1, q_count stays 0.
  - mispredict_count driven past 0xFFFF -> holds 0xFFFF.
